// File: rtl/oo_scoreboard_ring.sv
// In-order issue / out-of-order writeback / in-order commit scoreboard.
// Entries live in a ring indexed by trans_id; head is the oldest entry and tail is the next free slot.
// Operand lookup reports the youngest in-flight writer of each source register.
module oo_scoreboard_ring #(
  parameter int DEPTH        = 8,
  parameter int IDX_W        = $clog2(DEPTH),
  parameter int WB_PORTS     = 2,
  parameter int COMMIT_PORTS = 2,
  parameter int REG_W        = 5
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush_i,
  input  logic                          issue_valid_i,
  output logic                          issue_ready_o,
  input  logic [REG_W-1:0]              issue_rd_i,
  input  logic [31:0]                   issue_pc_i,
  output logic [IDX_W-1:0]              issue_id_o,
  input  logic [WB_PORTS-1:0]           wb_valid_i,
  input  logic [WB_PORTS*IDX_W-1:0]     wb_idx_i,
  input  logic [WB_PORTS*32-1:0]        wb_data_i,
  input  logic [WB_PORTS-1:0]           wb_ex_i,
  output logic [COMMIT_PORTS-1:0]       commit_valid_o,
  input  logic [COMMIT_PORTS-1:0]       commit_ready_i,
  output logic [COMMIT_PORTS*REG_W-1:0] commit_rd_o,
  output logic [COMMIT_PORTS*32-1:0]    commit_data_o,
  output logic [COMMIT_PORTS*32-1:0]    commit_pc_o,
  output logic [COMMIT_PORTS-1:0]       commit_ex_o,
  input  logic [2*REG_W-1:0]            rs_addr_i,
  output logic [1:0]                    rs_busy_o,
  output logic [1:0]                    rs_fwd_valid_o,
  output logic [2*32-1:0]               rs_data_o
);

  logic             valid_q [DEPTH];
  logic             valid_d [DEPTH];
  logic             done_q  [DEPTH];
  logic             done_d  [DEPTH];
  logic             ex_q    [DEPTH];
  logic             ex_d    [DEPTH];
  logic [REG_W-1:0] rd_q    [DEPTH];
  logic [REG_W-1:0] rd_d    [DEPTH];
  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      pc_d    [DEPTH];
  logic [31:0]      data_q  [DEPTH];
  logic [31:0]      data_d  [DEPTH];

  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W:0]   cnt_q,  cnt_d;

  logic                    issue_acc;
  logic [COMMIT_PORTS-1:0] retire;
  logic [IDX_W:0]          n_ret;

  // Issue handshake is based on the registered count only, so a full ring stalls even while committing.
  always_comb begin
    issue_ready_o = (cnt_q < (IDX_W+1)'(DEPTH));
    issue_id_o    = tail_q;
    issue_acc     = issue_valid_i & issue_ready_o;
  end

  // Commit lanes view head+i; a lane is valid only if every older lane is valid too.
  always_comb begin
    logic             chain;
    logic [IDX_W-1:0] idx;
    chain          = 1'b1;
    idx            = '0;
    commit_valid_o = '0;
    commit_rd_o    = '0;
    commit_data_o  = '0;
    commit_pc_o    = '0;
    commit_ex_o    = '0;
    for (int i = 0; i < COMMIT_PORTS; i++) begin
      idx   = head_q + IDX_W'(i);
      chain = chain & valid_q[idx] & done_q[idx];
      commit_valid_o[i]             = chain;
      commit_rd_o[i*REG_W +: REG_W] = rd_q[idx];
      commit_data_o[i*32 +: 32]     = data_q[idx];
      commit_pc_o[i*32 +: 32]       = pc_q[idx];
      commit_ex_o[i]                = ex_q[idx];
    end
  end

  // Retire the acknowledged prefix of valid lanes; a gap in commit_ready stops everything behind it.
  always_comb begin
    logic chain;
    chain  = 1'b1;
    retire = '0;
    n_ret  = '0;
    for (int i = 0; i < COMMIT_PORTS; i++) begin
      chain     = chain & commit_valid_o[i] & commit_ready_i[i];
      retire[i] = chain;
      n_ret     = n_ret + {{IDX_W{1'b0}}, chain};
    end
  end

  // Youngest-writer lookup: walk oldest to youngest so the youngest match overrides.
  always_comb begin
    logic [REG_W-1:0] addr;
    logic [IDX_W-1:0] idx;
    addr           = '0;
    idx            = '0;
    rs_busy_o      = '0;
    rs_fwd_valid_o = '0;
    rs_data_o      = '0;
    for (int r = 0; r < 2; r++) begin
      addr = rs_addr_i[r*REG_W +: REG_W];
      for (int k = DEPTH-1; k >= 0; k--) begin
        idx = tail_q - IDX_W'(k + 1);
        if (((IDX_W+1)'(k) < cnt_q) && valid_q[idx] && (rd_q[idx] == addr)) begin
          rs_busy_o[r]       = ~done_q[idx];
          rs_fwd_valid_o[r]  = done_q[idx];
          rs_data_o[r*32 +: 32] = done_q[idx] ? data_q[idx] : 32'h0;
        end
      end
      if (addr == '0) begin
        rs_busy_o[r]          = 1'b0;
        rs_fwd_valid_o[r]     = 1'b0;
        rs_data_o[r*32 +: 32] = 32'h0;
      end
    end
  end

  // Next ring state: writeback, then retire, then issue; flush overrides everything.
  always_comb begin
    logic [IDX_W-1:0] widx;
    logic [IDX_W-1:0] cidx;
    widx   = '0;
    cidx   = '0;
    valid_d = valid_q;
    done_d  = done_q;
    ex_d    = ex_q;
    rd_d    = rd_q;
    pc_d    = pc_q;
    data_d  = data_q;
    head_d  = head_q + n_ret[IDX_W-1:0];
    tail_d  = tail_q;
    cnt_d   = cnt_q + {{IDX_W{1'b0}}, issue_acc} - n_ret;

    // Highest port first so the lowest-numbered port lands last and wins.
    for (int p = WB_PORTS-1; p >= 0; p--) begin
      widx = wb_idx_i[p*IDX_W +: IDX_W];
      if (wb_valid_i[p] && valid_q[widx]) begin
        done_d[widx] = 1'b1;
        data_d[widx] = wb_data_i[p*32 +: 32];
        ex_d[widx]   = wb_ex_i[p];
      end
    end

    for (int i = 0; i < COMMIT_PORTS; i++) begin
      cidx = head_q + IDX_W'(i);
      if (retire[i]) begin
        valid_d[cidx] = 1'b0;
        done_d[cidx]  = 1'b0;
      end
    end

    // The tail slot is never valid when issue is allowed, so it cannot collide with retire or writeback.
    if (issue_acc) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      ex_d[tail_q]    = 1'b0;
      rd_d[tail_q]    = issue_rd_i;
      pc_d[tail_q]    = issue_pc_i;
      tail_d          = tail_q + IDX_W'(1);
    end

    if (flush_i) begin
      for (int e = 0; e < DEPTH; e++) begin
        valid_d[e] = 1'b0;
        done_d[e]  = 1'b0;
      end
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < DEPTH; e++) begin
        valid_q[e] <= 1'b0;
        done_q[e]  <= 1'b0;
        ex_q[e]    <= 1'b0;
        rd_q[e]    <= '0;
        pc_q[e]    <= '0;
        data_q[e]  <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      ex_q    <= ex_d;
      rd_q    <= rd_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_oo_scoreboard_ring.sv
// Bench for oo_scoreboard_ring: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_oo_scoreboard_ring;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;
  localparam int WBP   = 2;
  localparam int CP    = 2;
  localparam int REG_W = 5;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic                  flush_i;
  logic                  issue_valid_i;
  logic                  issue_ready_o;
  logic [REG_W-1:0]      issue_rd_i;
  logic [31:0]           issue_pc_i;
  logic [IDX_W-1:0]      issue_id_o;
  logic [WBP-1:0]        wb_valid_i;
  logic [WBP*IDX_W-1:0]  wb_idx_i;
  logic [WBP*32-1:0]     wb_data_i;
  logic [WBP-1:0]        wb_ex_i;
  logic [CP-1:0]         commit_valid_o;
  logic [CP-1:0]         commit_ready_i;
  logic [CP*REG_W-1:0]   commit_rd_o;
  logic [CP*32-1:0]      commit_data_o;
  logic [CP*32-1:0]      commit_pc_o;
  logic [CP-1:0]         commit_ex_o;
  logic [2*REG_W-1:0]    rs_addr_i;
  logic [1:0]            rs_busy_o;
  logic [1:0]            rs_fwd_valid_o;
  logic [63:0]           rs_data_o;

  oo_scoreboard_ring #(.DEPTH(DEPTH), .WB_PORTS(WBP), .COMMIT_PORTS(CP), .REG_W(REG_W)) dut (
    .clock(clock), .reset(reset), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_rd_i(issue_rd_i), .issue_pc_i(issue_pc_i), .issue_id_o(issue_id_o),
    .wb_valid_i(wb_valid_i), .wb_idx_i(wb_idx_i), .wb_data_i(wb_data_i), .wb_ex_i(wb_ex_i),
    .commit_valid_o(commit_valid_o), .commit_ready_i(commit_ready_i),
    .commit_rd_o(commit_rd_o), .commit_data_o(commit_data_o),
    .commit_pc_o(commit_pc_o), .commit_ex_o(commit_ex_o),
    .rs_addr_i(rs_addr_i), .rs_busy_o(rs_busy_o),
    .rs_fwd_valid_o(rs_fwd_valid_o), .rs_data_o(rs_data_o)
  );

  typedef struct {
    logic [IDX_W-1:0] id;
    logic [REG_W-1:0] rd;
    logic [31:0]      pc;
    logic             done;
    logic             ex;
    logic [31:0]      data;
  } ent_t;

  ent_t             mq[$];
  logic [IDX_W-1:0] mtail;
  int               n_vec = 0;
  int               n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [CP-1:0] m_cv();
    logic [CP-1:0] v;
    v = '0;
    for (int i = 0; i < CP; i++)
      if (i < mq.size() && mq[i].done && (i == 0 || v[(i == 0) ? 0 : i-1])) v[i] = 1'b1;
    return v;
  endfunction

  task automatic compare_all();
    logic [CP-1:0]    cv;
    logic [REG_W-1:0] a;
    logic             eb, ef;
    logic [31:0]      ed;
    cv = m_cv();
    chk("issue_ready", {63'b0, issue_ready_o}, {63'b0, (mq.size() < DEPTH)});
    chk("issue_id", {61'b0, issue_id_o}, {61'b0, mtail});
    chk("commit_valid", {62'b0, commit_valid_o}, {62'b0, cv});
    for (int i = 0; i < CP; i++) begin
      if (cv[i]) begin
        chk("commit_rd", {59'b0, commit_rd_o[i*REG_W +: REG_W]}, {59'b0, mq[i].rd});
        chk("commit_data", {32'b0, commit_data_o[i*32 +: 32]}, {32'b0, mq[i].data});
        chk("commit_pc", {32'b0, commit_pc_o[i*32 +: 32]}, {32'b0, mq[i].pc});
        chk("commit_ex", {63'b0, commit_ex_o[i]}, {63'b0, mq[i].ex});
      end
    end
    for (int r = 0; r < 2; r++) begin
      a = rs_addr_i[r*REG_W +: REG_W];
      eb = 1'b0; ef = 1'b0; ed = '0;
      if (a != '0) begin
        for (int k = mq.size() - 1; k >= 0; k--) begin
          if (mq[k].rd == a) begin
            if (mq[k].done) begin ef = 1'b1; ed = mq[k].data; end
            else eb = 1'b1;
            break;
          end
        end
      end
      chk("rs_busy", {63'b0, rs_busy_o[r]}, {63'b0, eb});
      chk("rs_fwd_valid", {63'b0, rs_fwd_valid_o[r]}, {63'b0, ef});
      if (ef) chk("rs_data", {32'b0, rs_data_o[r*32 +: 32]}, {32'b0, ed});
    end
  endtask

  // Model of one clock edge under the currently driven inputs.
  task automatic model_step();
    logic [CP-1:0]    cv;
    logic             rdy;
    logic [DEPTH-1:0] hit;
    logic [IDX_W-1:0] wi;
    ent_t             e;
    int               n;
    if (flush_i) begin
      mq.delete();
      mtail = '0;
      return;
    end
    cv  = m_cv();
    rdy = (mq.size() < DEPTH);
    hit = '0;
    for (int p = 0; p < WBP; p++) begin
      wi = wb_idx_i[p*IDX_W +: IDX_W];
      if (wb_valid_i[p] && !hit[wi]) begin
        hit[wi] = 1'b1;
        for (int j = 0; j < mq.size(); j++) begin
          if (mq[j].id == wi) begin
            e = mq[j];
            e.done = 1'b1;
            e.data = wb_data_i[p*32 +: 32];
            e.ex   = wb_ex_i[p];
            mq[j]  = e;
          end
        end
      end
    end
    n = 0;
    for (int i = 0; i < CP; i++)
      if (cv[i] && commit_ready_i[i] && n == i) n++;
    for (int i = 0; i < n; i++) void'(mq.pop_front());
    if (issue_valid_i && rdy) begin
      e.id = mtail; e.rd = issue_rd_i; e.pc = issue_pc_i;
      e.done = 1'b0; e.ex = 1'b0; e.data = '0;
      mq.push_back(e);
      mtail = mtail + 3'd1;
    end
  endtask

  // Called at a falling edge with inputs set; returns at the next falling edge.
  task automatic step();
    #1;
    compare_all();
    model_step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle();
    flush_i = 0; issue_valid_i = 0; issue_rd_i = '0; issue_pc_i = '0;
    wb_valid_i = '0; wb_idx_i = '0; wb_data_i = '0; wb_ex_i = '0;
    commit_ready_i = '0; rs_addr_i = '0;
  endtask

  task automatic wb0(input logic [IDX_W-1:0] id, input logic [31:0] d);
    wb_valid_i = 2'b01; wb_idx_i = {3'd0, id}; wb_data_i = {32'd0, d}; wb_ex_i = '0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    mtail = '0;
    repeat (3) @(negedge clock);
    #1;
    chk("reset_ready", {63'b0, issue_ready_o}, 64'd1);
    chk("reset_id", {61'b0, issue_id_o}, 64'd0);
    chk("reset_cv", {62'b0, commit_valid_o}, 64'd0);
    chk("reset_busy", {62'b0, rs_busy_o}, 64'd0);
    chk("reset_fwd", {62'b0, rs_fwd_valid_o}, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Fill the ring without writeback.
    for (int i = 0; i < DEPTH; i++) begin
      issue_valid_i = 1; issue_rd_i = REG_W'(i + 1); issue_pc_i = 32'h1000 + 32'(i * 4);
      step();
    end
    chk("full_ready", {63'b0, issue_ready_o}, 64'd0);
    chk("full_id_wrap", {61'b0, issue_id_o}, 64'd0);
    chk("full_cv", {62'b0, commit_valid_o}, 64'd0);

    // Flush on a full ring with concurrent issue and writeback.
    flush_i = 1; issue_valid_i = 1; wb_valid_i = 2'b11; wb_idx_i = {3'd1, 3'd0};
    commit_ready_i = 2'b11;
    step();
    idle();
    #1;
    chk("flush_ready", {63'b0, issue_ready_o}, 64'd1);
    chk("flush_id", {61'b0, issue_id_o}, 64'd0);
    chk("flush_cv", {62'b0, commit_valid_o}, 64'd0);

    // Out-of-order writeback, in-order commit.
    for (int i = 0; i < 3; i++) begin
      issue_valid_i = 1; issue_rd_i = REG_W'(i + 1); issue_pc_i = 32'h100 + 32'(i * 4);
      step();
    end
    idle();
    wb0(3'd2, 32'h22); step();
    wb0(3'd0, 32'h11); step();
    idle(); #1;
    chk("ooo_cv_lane0", {62'b0, commit_valid_o}, 64'd1);
    chk("ooo_lane0_data", {32'b0, commit_data_o[31:0]}, 64'h11);
    commit_ready_i = 2'b01; step();
    idle(); #1;
    chk("ooo_id2_blocked", {62'b0, commit_valid_o}, 64'd0);
    wb0(3'd1, 32'h33); step();
    idle(); #1;
    chk("ooo_both_valid", {62'b0, commit_valid_o}, 64'd3);
    commit_ready_i = 2'b10; step();
    chk("hole_no_retire", {62'b0, commit_valid_o}, 64'd3);
    chk("hole_head_same", {32'b0, commit_pc_o[31:0]}, 64'h104);
    commit_ready_i = 2'b11; step();
    idle(); #1;
    chk("pair_retired", {62'b0, commit_valid_o}, 64'd0);
    chk("pair_tail", {61'b0, issue_id_o}, 64'd3);

    // Youngest-writer lookup.
    flush_i = 1; step(); idle();
    issue_valid_i = 1; issue_rd_i = 5'd5; issue_pc_i = 32'h200; step();
    issue_pc_i = 32'h204; step();
    idle();
    wb0(3'd0, 32'hAA); step();
    idle();
    rs_addr_i = {5'd0, 5'd5}; #1;
    chk("lookup_busy", {62'b0, rs_busy_o}, 64'd1);
    chk("lookup_not_fwd", {62'b0, rs_fwd_valid_o}, 64'd0);
    wb0(3'd1, 32'hBB); step();
    wb_valid_i = '0; #1;
    chk("lookup_fwd", {62'b0, rs_fwd_valid_o}, 64'd1);
    chk("lookup_data", {32'b0, rs_data_o[31:0]}, 64'hBB);
    issue_valid_i = 1; issue_rd_i = 5'd0; issue_pc_i = 32'h208; step();
    idle(); #1;
    chk("lookup_x0_busy", {62'b0, rs_busy_o}, 64'd0);
    chk("lookup_x0_fwd", {62'b0, rs_fwd_valid_o}, 64'd0);
    step();

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc == 700) begin
        reset = 1'b1;
        #1;
        mq.delete();
        mtail = '0;
        compare_all();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
      end
      flush_i        = ($urandom_range(0, 63) == 0);
      issue_valid_i  = ($urandom_range(0, 9) < 6);
      issue_rd_i     = REG_W'($urandom_range(0, 7));
      issue_pc_i     = $urandom;
      commit_ready_i = CP'($urandom);
      rs_addr_i      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      for (int p = 0; p < WBP; p++) begin
        wb_valid_i[p] = ($urandom_range(0, 2) != 0);
        if (mq.size() > 0 && $urandom_range(0, 3) != 0)
          wb_idx_i[p*IDX_W +: IDX_W] = mq[$urandom_range(0, mq.size() - 1)].id;
        else
          wb_idx_i[p*IDX_W +: IDX_W] = IDX_W'($urandom);
        wb_data_i[p*32 +: 32] = $urandom;
        wb_ex_i[p] = ($urandom_range(0, 7) == 0);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
